// File: rtl/cpu7_ifu_imm_enc.sv
// -----------------------------------------------------------------------------
// cpu7_ifu_imm_enc
//
// Instruction/immediate encoder feeding the IFU instruction-injection port.
// A request (kind, rd, rj, 32-bit value) is split into LoongArch immediate or
// offset fields and streamed out as one or two encoded instructions.
//
//   kind 0 LI   : lu12i.w rd, v[31:12]  then  ori rd, rd, v[11:0]
//   kind 1 B    : b offs26 (byte offset v, word aligned, +/-128 MiB)
//   kind 2 ADDI : addi.w rd, rj, si12
//   kind 3      : reserved, rejected
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_kind, req_rd, req_rj,
//   req_value                        request fields, captured at handshake
//   inst_valid/inst_ready            instruction handshake
//   inst, inst_last                  encoded word, final word of the request
//   err_valid, err_code              one-cycle reject pulse and reason
//                                    (1 unencodable, 2 misaligned, 3 kind)
//
// Build option
//   CPU7_IMM_ENC_LI_SHORT_EN : when defined, LI emits a single addi.w (value
//   fits si12) or a single lu12i.w (low 12 bits zero) instead of the pair.
// -----------------------------------------------------------------------------
module cpu7_ifu_imm_enc (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rj,
   input  logic [31:0] req_value,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic        inst_last,
   output logic        err_valid,
   output logic [1:0]  err_code
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EMIT1 = 2'd1;
   localparam logic [1:0] ST_EMIT2 = 2'd2;

   localparam logic [1:0] KIND_LI   = 2'd0;
   localparam logic [1:0] KIND_B    = 2'd1;
   localparam logic [1:0] KIND_ADDI = 2'd2;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_IMM     = 2'd1;
   localparam logic [1:0] ERR_ALIGN   = 2'd2;
   localparam logic [1:0] ERR_KIND    = 2'd3;

   logic [1:0]  r_state;
   logic        r_live;      // low until the first edge after reset release
   logic [31:0] r_inst;
   logic [31:0] r_lo;        // second word of a two-instruction request
   logic        r_single;
   logic        r_inst_valid;
   logic        r_inst_last;
   logic        r_err_valid;
   logic [1:0]  r_err_code;

   logic        w_hs;
   logic        w_fits_si12;
   logic        w_fits_offs;
   logic [31:0] w_lu12i;
   logic [31:0] w_ori;
   logic [31:0] w_first;
   logic [31:0] w_second;
   logic        w_single;
   logic [1:0]  w_err;

   assign req_ready  = r_live && (r_state == ST_IDLE);
   assign w_hs       = req_valid && req_ready;

   assign inst_valid = r_inst_valid;
   assign inst       = r_inst;
   assign inst_last  = r_inst_last;
   assign err_valid  = r_err_valid;
   assign err_code   = r_err_code;

   // A value is a valid si12 when bits [31:11] are all copies of the sign.
   assign w_fits_si12 = (&req_value[31:11]) || !(|req_value[31:11]);
   // A 28-bit signed byte offset: bits [31:27] all copies of the sign.
   assign w_fits_offs = (&req_value[31:27]) || !(|req_value[31:27]);

   assign w_lu12i = {7'b0001010, req_value[31:12], req_rd};
   assign w_ori   = {10'b0000001110, req_value[11:0], req_rd, req_rd};

   // NOTE: every output of this block gets a default first so no path leaves
   // it unassigned; that is what keeps combinational logic free of latches.
   always_comb begin
      w_err    = ERR_NONE;
      w_first  = 32'd0;
      w_second = 32'd0;
      w_single = 1'b1;
      case (req_kind)
         KIND_LI: begin
`ifdef CPU7_IMM_ENC_LI_SHORT_EN
            if (w_fits_si12) begin
               w_first = {10'b0000001010, req_value[11:0], 5'd0, req_rd};
            end else if (req_value[11:0] == 12'd0) begin
               w_first = w_lu12i;
            end else begin
               w_first  = w_lu12i;
               w_second = w_ori;
               w_single = 1'b0;
            end
`else
            w_first  = w_lu12i;
            w_second = w_ori;
            w_single = 1'b0;
`endif
         end
         KIND_B: begin
            // Misalignment is reported ahead of range.
            if (req_value[1:0] != 2'b00) begin
               w_err = ERR_ALIGN;
            end else if (!w_fits_offs) begin
               w_err = ERR_IMM;
            end else begin
               w_first = {6'b010100, req_value[17:2], req_value[27:18]};
            end
         end
         KIND_ADDI: begin
            if (!w_fits_si12) begin
               w_err = ERR_IMM;
            end else begin
               w_first = {10'b0000001010, req_value[11:0], req_rj, req_rd};
            end
         end
         default: w_err = ERR_KIND;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_live       <= 1'b0;
         r_inst       <= 32'd0;
         r_lo         <= 32'd0;
         r_single     <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst_last  <= 1'b0;
         r_err_valid  <= 1'b0;
         r_err_code   <= 2'd0;
      end else begin
         r_live      <= 1'b1;
         r_err_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  if (w_err != ERR_NONE) begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= w_err;
                  end else begin
                     r_inst       <= w_first;
                     r_lo         <= w_second;
                     r_single     <= w_single;
                     r_inst_valid <= 1'b1;
                     r_inst_last  <= w_single;
                     r_state      <= ST_EMIT1;
                  end
               end
            end
            ST_EMIT1: begin
               if (inst_ready) begin
                  if (r_single) begin
                     r_inst_valid <= 1'b0;
                     r_inst_last  <= 1'b0;
                     r_state      <= ST_IDLE;
                  end else begin
                     // Second word follows with no bubble.
                     r_inst      <= r_lo;
                     r_inst_last <= 1'b1;
                     r_state     <= ST_EMIT2;
                  end
               end
            end
            ST_EMIT2: begin
               if (inst_ready) begin
                  r_inst_valid <= 1'b0;
                  r_inst_last  <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_inst_valid <= 1'b0;
               r_inst_last  <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu7_ifu_imm_enc.sv
// -----------------------------------------------------------------------------
// tb_cpu7_ifu_imm_enc
//
// Self-checking bench for cpu7_ifu_imm_enc. Expected words come from an
// arithmetic model of the LoongArch field layout (shifts and masks on the
// request value), compared against the DUT at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_cpu7_ifu_imm_enc;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_kind;
   logic [4:0]  req_rd;
   logic [4:0]  req_rj;
   logic [31:0] req_value;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic        inst_last;
   logic        err_valid;
   logic [1:0]  err_code;

   int errors = 0;
   int checks = 0;

   cpu7_ifu_imm_enc dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_kind   (req_kind),
      .req_rd     (req_rd),
      .req_rj     (req_rj),
      .req_value  (req_value),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .inst_last  (inst_last),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: number of words, the words, and the reject code.
   function automatic void model(input logic [1:0] k, input logic [4:0] rd,
                                 input logic [4:0] rj, input logic [31:0] v,
                                 output int n, output logic [31:0] w0,
                                 output logic [31:0] w1, output logic [1:0] e);
      int sv;
      int offs;
      logic [31:0] hi, lo, rdw, rjw;
      sv  = v;
      rdw = {27'd0, rd};
      rjw = {27'd0, rj};
      n = 0; w0 = 0; w1 = 0; e = 0;
      hi = (32'd10 << 25) | ((v >> 12) << 5) | rdw;
      lo = (32'd14 << 22) | ((v & 32'hFFF) << 10) | (rdw << 5) | rdw;
      case (k)
         2'd0: begin
`ifdef CPU7_IMM_ENC_LI_SHORT_EN
            if (sv >= -2048 && sv <= 2047) begin
               n = 1; w0 = (32'd10 << 22) | ((v & 32'hFFF) << 10) | rdw;
            end else if ((v & 32'hFFF) == 0) begin
               n = 1; w0 = hi;
            end else begin
               n = 2; w0 = hi; w1 = lo;
            end
`else
            n = 2; w0 = hi; w1 = lo;
`endif
         end
         2'd1: begin
            if ((v % 4) != 0) e = 2;
            else if (sv < -(2 ** 27) || sv > (2 ** 27) - 4) e = 1;
            else begin
               offs = sv / 4;
               n  = 1;
               w0 = (32'd20 << 26) | ((offs & 32'hFFFF) << 10) | ((offs >> 16) & 32'h3FF);
            end
         end
         2'd2: begin
            if (sv < -2048 || sv > 2047) e = 1;
            else begin
               n  = 1;
               w0 = (32'd10 << 22) | ((v & 32'hFFF) << 10) | (rjw << 5) | rdw;
            end
         end
         default: e = 3;
      endcase
   endfunction

   // Issue one request and check everything it should produce. Starts and
   // ends at a falling edge. 'stall' holds inst_ready low on the first word.
   task automatic run_req(input logic [1:0] k, input logic [4:0] rd,
                          input logic [4:0] rj, input logic [31:0] v,
                          input int stall, input string name);
      int n;
      int t;
      logic [31:0] w [2];
      logic [31:0] w0, w1;
      logic [1:0]  e;
      model(k, rd, rj, v, n, w0, w1, e);
      w[0] = w0;
      w[1] = w1;
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout req_ready=%b required 1", name, req_ready);
      end
      req_kind  = k;
      req_rd    = rd;
      req_rj    = rj;
      req_value = v;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      // Scramble the request bus: the DUT must have captured it already.
      req_valid = 1'b0;
      req_kind  = 2'($urandom);
      req_rd    = 5'($urandom);
      req_rj    = 5'($urandom);
      req_value = $urandom;
      @(negedge clk);
      if (e != 0) begin
         checks++;
         if (err_valid !== 1'b1 || err_code !== e || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s err err_valid=%b err_code=%0d inst_valid=%b required 1/%0d/0",
                     name, err_valid, err_code, inst_valid, e);
         end
         @(negedge clk);
         checks++;
         if (err_valid !== 1'b0 || req_ready !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s err_pulse err_valid=%b req_ready=%b inst_valid=%b required 0/1/0",
                     name, err_valid, req_ready, inst_valid);
         end
      end else begin
         for (int i = 0; i < n; i++) begin
            for (int s = 0; s < ((i == 0) ? stall : 0); s++) begin
               inst_ready = 1'b0;
               checks++;
               if (inst_valid !== 1'b1 || inst !== w[i] || inst_last !== (i == n - 1)) begin
                  errors++;
                  $display("FAIL %s stall%0d inst=%h valid=%b last=%b required %h/1/%b",
                           name, s, inst, inst_valid, inst_last, w[i], (i == n - 1));
               end
               @(negedge clk);
            end
            inst_ready = 1'b1;
            checks++;
            if (inst_valid !== 1'b1 || inst !== w[i] || inst_last !== (i == n - 1) ||
                req_ready !== 1'b0 || err_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s word%0d inst=%h valid=%b last=%b ready=%b err=%b required %h/1/%b/0/0",
                        name, i, inst, inst_valid, inst_last, req_ready, err_valid,
                        w[i], (i == n - 1));
            end
            @(posedge clk);
            #1;
            inst_ready = 1'b0;
            @(negedge clk);
         end
         checks++;
         if (inst_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s done inst_valid=%b req_ready=%b required 0/1",
                     name, inst_valid, req_ready);
         end
      end
   endtask

   task automatic test_reset;
      resetn     = 1'b0;
      req_valid  = 1'b0;
      req_kind   = 2'd0;
      req_rd     = 5'd0;
      req_rj     = 5'd0;
      req_value  = 32'd0;
      inst_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 ||
          inst_last !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'd0) begin
         errors++;
         $display("FAIL reset_values ready=%b valid=%b inst=%h last=%b err=%b code=%0d required all 0",
                  req_ready, inst_valid, inst, inst_last, err_valid, err_code);
      end
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release req_ready=%b inst_valid=%b required 1/0",
                  req_ready, inst_valid);
      end
   endtask

   task automatic test_li;
      run_req(2'd0, 5'd5, 5'd0, 32'h12345678, 3, "li_12345678");
      run_req(2'd0, 5'd4, 5'd0, 32'hFFFFFFFF, 0, "li_ffffffff");
      run_req(2'd0, 5'd7, 5'd0, 32'h00000000, 1, "li_zero");
      run_req(2'd0, 5'd31, 5'd0, 32'hABCDE000, 0, "li_low_zero");
      run_req(2'd0, 5'd1, 5'd0, 32'h000007FF, 2, "li_si12_max");
   endtask

   task automatic test_branch;
      run_req(2'd1, 5'd0, 5'd0, 32'h00000400, 0, "b_400");
      run_req(2'd1, 5'd0, 5'd0, 32'h00000402, 0, "b_misaligned");
      run_req(2'd1, 5'd0, 5'd0, 32'h08000000, 0, "b_over");
      run_req(2'd1, 5'd0, 5'd0, 32'h07FFFFFC, 0, "b_max");
      run_req(2'd1, 5'd0, 5'd0, 32'hF8000000, 0, "b_min");
      run_req(2'd1, 5'd0, 5'd0, 32'hF7FFFFFC, 0, "b_under");
      run_req(2'd1, 5'd0, 5'd0, 32'hFFFFFFFC, 1, "b_minus4");
   endtask

   task automatic test_addi;
      run_req(2'd2, 5'd1, 5'd2, 32'h00000800, 0, "addi_800");
      run_req(2'd2, 5'd1, 5'd2, 32'hFFFFF800, 0, "addi_m2048");
      run_req(2'd2, 5'd9, 5'd17, 32'h000007FF, 0, "addi_2047");
      run_req(2'd2, 5'd3, 5'd3, 32'hFFFFF7FF, 0, "addi_m2049");
   endtask

   task automatic test_reserved;
      run_req(2'd3, 5'd1, 5'd2, 32'h00000000, 0, "kind3");
   endtask

   task automatic test_random;
      logic [31:0] v;
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = {{20{1'($urandom)}}, 12'($urandom)};
            2: v = {{5{1'($urandom)}}, 25'($urandom), 2'b00};
            default: v = {20'($urandom), 12'd0};
         endcase
         run_req(2'($urandom), 5'($urandom), 5'($urandom), v,
                 int'($urandom_range(0, 2)), "random");
      end
   endtask

   // Requests offered continuously: each must be accepted exactly one
   // cycle after the last word of the previous one leaves.
   task automatic test_back_to_back;
      for (int i = 0; i < 6; i++) begin
         run_req(2'(i % 3), 5'(i + 1), 5'(i + 2), 32'h00012000 + 32'(i * 4), 0, "b2b");
      end
   endtask

   task automatic test_reset_mid;
      run_req(2'd2, 5'd1, 5'd1, 32'd1, 0, "pre_reset");
      req_kind  = 2'd0;
      req_rd    = 5'd5;
      req_value = 32'h12345678;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      @(negedge clk);
      inst_ready = 1'b1;
      @(posedge clk);
      #1;
      inst_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_last !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_emit2 valid=%b last=%b required 1/1", inst_valid, inst_last);
      end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'd0 ||
          inst_last !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'd0) begin
         errors++;
         $display("FAIL rst_mid_async ready=%b valid=%b inst=%h last=%b err=%b code=%0d required all 0",
                  req_ready, inst_valid, inst, inst_last, err_valid, err_code);
      end
      @(negedge clk);
      resetn     = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_stale%0d inst_valid=%b req_ready=%b required 0/1",
                     i, inst_valid, req_ready);
         end
      end
      inst_ready = 1'b0;
      run_req(2'd0, 5'd6, 5'd0, 32'h0000ABCD, 0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_li();
      test_branch();
      test_addi();
      test_reserved();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
